// File: rtl/world_scatter.sv
// world_scatter: each accepted start either counts down the generation timer or
// scatters NUM_ITEMS x NUM_FIELDS memory-write instructions to a handshaked datapath.
module world_scatter #(
  parameter int unsigned          NUM_ITEMS       = 8,
  parameter int unsigned          NUM_FIELDS      = 2,
  parameter int unsigned          DATA_W          = 8,
  parameter int unsigned          RAND_W          = 16,
  parameter int unsigned          ADDR_W          = 8,
  parameter int unsigned          OPCODE_W        = 4,
  parameter logic [OPCODE_W-1:0]  OPCODE_MEMWRITE = 4'd2,
  parameter int unsigned          BASE_ADDR       = 0,
  parameter int unsigned          FIELD_STRIDE    = 16,
  parameter int unsigned          DELAY_W         = 16,
  parameter int unsigned          TIMEOUT         = 255
) (
  input  logic                                clock_i,
  input  logic                                resetn_i,
  input  logic                                start_i,
  input  logic                                mode_i,
  input  logic [RAND_W-1:0]                   rand_i,
  input  logic [DELAY_W-1:0]                  gen_duration_i,
  output logic                                finished_o,
  output logic                                refreshed_o,
  output logic                                error_o,
  output logic [DATA_W-1:0]                   last_result_o,
  output logic                                start_dp_o,
  output logic [DATA_W+ADDR_W+OPCODE_W-1:0]   instruction_dp_o,
  input  logic                                finished_dp_i,
  input  logic [DATA_W-1:0]                   result_dp_i
);

  localparam int unsigned IT_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam int unsigned FD_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned INSTR_W = DATA_W + ADDR_W + OPCODE_W;
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(NUM_ITEMS - 1);
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(NUM_FIELDS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TIMER = 3'd1,
    S_ISSUE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 error_q, error_d;
  logic                 refreshed_q, refreshed_d;
  logic                 start_dp_q, start_dp_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    last_q, last_d;
  logic [DELAY_W-1:0]   gen_q, gen_d;
  logic [IT_W-1:0]      item_q, item_d;
  logic [FD_W-1:0]      field_q, field_d;
  logic [TO_W-1:0]      to_q, to_d;

  logic [DATA_W-1:0]    data_s;
  logic [IT_W-1:0]      nxt_item_s;
  logic [FD_W-1:0]      nxt_field_s;
  logic                 pass_end_s;
  logic                 unused_s;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [DATA_W-1:0] data,
                                                    input logic [IT_W-1:0]   item,
                                                    input logic [FD_W-1:0]   field);
    logic [ADDR_W-1:0] addr;
    addr = ADDR_W'(BASE_ADDR + FIELD_STRIDE * 32'(field) + 32'(item));
    return {data, addr, OPCODE_MEMWRITE};
  endfunction

  assign data_s      = mode_q ? {DATA_W{1'b0}} : rand_i[DATA_W-1:0];
  assign unused_s    = ^rand_i;
  assign pass_end_s  = (field_q == FD_LAST) && (item_q == IT_LAST);
  assign nxt_field_s = (field_q == FD_LAST) ? {FD_W{1'b0}} : FD_W'(field_q + 1'b1);
  assign nxt_item_s  = (field_q == FD_LAST) ? IT_W'(item_q + 1'b1) : item_q;

  // Next-state and datapath-request logic for the scatter sequencer.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    error_d     = error_q;
    refreshed_d = 1'b0;
    start_dp_d  = start_dp_q;
    instr_d     = instr_q;
    last_d      = last_q;
    gen_d       = gen_q;
    item_d      = item_q;
    field_d     = field_q;
    to_d        = to_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          error_d = 1'b0;
          item_d  = {IT_W{1'b0}};
          field_d = {FD_W{1'b0}};
          state_d = S_TIMER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TIMER: begin
        if (gen_q != {DELAY_W{1'b0}}) begin
          gen_d   = gen_q - DELAY_W'(1);
          state_d = S_DONE;
        end else begin
          gen_d      = gen_duration_i;
          start_dp_d = 1'b1;
          instr_d    = make_instr(data_s, item_q, field_q);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD: begin
        start_dp_d = 1'b0;
        to_d       = {TO_W{1'b0}};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (finished_dp_i) begin
          last_d  = result_dp_i;
          item_d  = nxt_item_s;
          field_d = nxt_field_s;
          if (pass_end_s) begin
            refreshed_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            start_dp_d = 1'b1;
            instr_d    = make_instr(data_s, nxt_item_s, nxt_field_s);
            state_d    = S_ISSUE;
          end
        end else if (to_q == TO_LAST) begin
          // Datapath went silent: abandon the rest of the pass.
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = TO_W'(to_q + 1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      error_q     <= 1'b0;
      refreshed_q <= 1'b0;
      start_dp_q  <= 1'b0;
      instr_q     <= {INSTR_W{1'b0}};
      last_q      <= {DATA_W{1'b0}};
      gen_q       <= {DELAY_W{1'b0}};
      item_q      <= {IT_W{1'b0}};
      field_q     <= {FD_W{1'b0}};
      to_q        <= {TO_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      error_q     <= error_d;
      refreshed_q <= refreshed_d;
      start_dp_q  <= start_dp_d;
      instr_q     <= instr_d;
      last_q      <= last_d;
      gen_q       <= gen_d;
      item_q      <= item_d;
      field_q     <= field_d;
      to_q        <= to_d;
    end
  end

  assign finished_o       = (state_q == S_IDLE);
  assign refreshed_o      = refreshed_q;
  assign error_o          = error_q;
  assign last_result_o    = last_q;
  assign start_dp_o       = start_dp_q;
  assign instruction_dp_o = instr_q;

endmodule

// File: tb/tb_world_scatter.sv
// Directed bench for world_scatter: 3 items x 2 fields at base 0x40, with an
// echoing datapath model that answers in the third WAIT cycle.
module tb_world_scatter;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        mode;
  logic [15:0] rnd;
  logic [15:0] gen_duration;
  logic        finished;
  logic        refreshed;
  logic        error_flag;
  logic [7:0]  last_result;
  logic        start_dp;
  logic [19:0] instruction_dp;
  logic        finished_dp;
  logic [7:0]  result_dp;

  int total = 0;
  int bad   = 0;

  logic [19:0] wr_log[$];
  int          refresh_cnt = 0;
  bit          dp_silent   = 1'b0;
  bit          force_early = 1'b0;
  logic [7:0]  exp_addr[6] = '{8'h40, 8'h50, 8'h41, 8'h51, 8'h42, 8'h52};

  world_scatter #(
    .NUM_ITEMS   (3),
    .NUM_FIELDS  (2),
    .BASE_ADDR   (32'h40),
    .FIELD_STRIDE(16)
  ) dut (
    .clock_i         (clock),
    .resetn_i        (resetn),
    .start_i         (start),
    .mode_i          (mode),
    .rand_i          (rnd),
    .gen_duration_i  (gen_duration),
    .finished_o      (finished),
    .refreshed_o     (refreshed),
    .error_o         (error_flag),
    .last_result_o   (last_result),
    .start_dp_o      (start_dp),
    .instruction_dp_o(instruction_dp),
    .finished_dp_i   (finished_dp),
    .result_dp_i     (result_dp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Datapath model and write monitor, evaluated on the falling edge.
  initial begin
    bit prev;
    int cnt;
    prev = 1'b0;
    cnt  = 0;
    finished_dp = 1'b0;
    result_dp   = 8'h00;
    forever begin
      @(negedge clock);
      finished_dp = 1'b0;
      if (!resetn) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (start_dp && !prev) wr_log.push_back(instruction_dp);
        if (prev && !start_dp) cnt = 1;
        else if (cnt != 0) cnt++;
        if (refreshed) refresh_cnt++;
        if (force_early && start_dp) begin
          finished_dp = 1'b1;
          result_dp   = 8'hEE;
        end else if (!dp_silent && cnt == 3) begin
          finished_dp = 1'b1;
          result_dp   = instruction_dp[19:12];
          cnt         = 0;
        end
        prev = start_dp;
      end
    end
  end

  task automatic do_start(input logic m);
    @(negedge clock);
    mode  = m;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int cycles, output bit ok);
    cycles = 0;
    while (!finished && cycles < max) begin
      @(negedge clock);
      cycles++;
    end
    ok = finished;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #1;
    total++; if (finished !== 1'b1) begin bad++; $display("FAIL reset_finished got=%b want=1", finished); end
    total++; if (start_dp !== 1'b0) begin bad++; $display("FAIL reset_start_dp got=%b want=0", start_dp); end
    total++; if (instruction_dp !== 20'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instruction_dp); end
    total++; if (refreshed !== 1'b0) begin bad++; $display("FAIL reset_refreshed got=%b want=0", refreshed); end
    total++; if (error_flag !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error_flag); end
    total++; if (last_result !== 8'h00) begin bad++; $display("FAIL reset_last got=%h want=00", last_result); end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_full_pass;
    int cyc; bit ok; logic [19:0] exp;
    gen_duration = 16'd2; rnd = 16'h12A5;
    wr_log.delete(); refresh_cnt = 0;
    do_start(1'b0);
    wait_idle(200, cyc, ok);
    total++; if (!ok || cyc != 32) begin bad++; $display("FAIL pass_cycles got=%0d want=32", cyc); end
    total++; if (wr_log.size() != 6) begin bad++; $display("FAIL pass_writes got=%0d want=6", wr_log.size()); end
    for (int j = 0; j < 6 && j < wr_log.size(); j++) begin
      exp = {8'hA5, exp_addr[j], 4'h2};
      total++; if (wr_log[j] !== exp) begin bad++; $display("FAIL pass_instr[%0d] got=%h want=%h", j, wr_log[j], exp); end
    end
    total++; if (refresh_cnt != 1) begin bad++; $display("FAIL pass_refreshed got=%0d want=1", refresh_cnt); end
    total++; if (last_result !== 8'hA5) begin bad++; $display("FAIL pass_last got=%h want=a5", last_result); end
    total++; if (error_flag !== 1'b0) begin bad++; $display("FAIL pass_error got=%b want=0", error_flag); end
  endtask

  task automatic test_skip;
    int cyc; bit ok; logic [19:0] exp;
    wr_log.delete(); refresh_cnt = 0;
    for (int s = 0; s < 2; s++) begin
      do_start(1'b0);
      total++; if (finished !== 1'b0) begin bad++; $display("FAIL skip%0d_timer got=%b want=0", s, finished); end
      @(negedge clock);
      total++; if (finished !== 1'b0 || start_dp !== 1'b0) begin bad++; $display("FAIL skip%0d_done got=%b%b want=00", s, finished, start_dp); end
      @(negedge clock);
      total++; if (finished !== 1'b1) begin bad++; $display("FAIL skip%0d_idle got=%b want=1", s, finished); end
    end
    total++; if (wr_log.size() != 0 || refresh_cnt != 0) begin bad++; $display("FAIL skip_quiet got=%0d/%0d want=0/0", wr_log.size(), refresh_cnt); end
    gen_duration = 16'd0; rnd = 16'h003C;
    do_start(1'b0);
    wait_idle(200, cyc, ok);
    total++; if (!ok || wr_log.size() != 6 || refresh_cnt != 1) begin bad++; $display("FAIL skip_third got=%0d/%0d want=6/1", wr_log.size(), refresh_cnt); end
    for (int j = 0; j < 6 && j < wr_log.size(); j++) begin
      exp = {8'h3C, exp_addr[j], 4'h2};
      total++; if (wr_log[j] !== exp) begin bad++; $display("FAIL third_instr[%0d] got=%h want=%h", j, wr_log[j], exp); end
    end
  endtask

  task automatic test_clear_mode;
    int cyc; bit ok; logic [19:0] exp;
    rnd = 16'h0077; wr_log.delete(); refresh_cnt = 0;
    do_start(1'b1);
    wait_idle(200, cyc, ok);
    total++; if (!ok || wr_log.size() != 6 || refresh_cnt != 1) begin bad++; $display("FAIL clear_pass got=%0d/%0d want=6/1", wr_log.size(), refresh_cnt); end
    for (int j = 0; j < 6 && j < wr_log.size(); j++) begin
      exp = {8'h00, exp_addr[j], 4'h2};
      total++; if (wr_log[j] !== exp) begin bad++; $display("FAIL clear_instr[%0d] got=%h want=%h", j, wr_log[j], exp); end
    end
    total++; if (last_result !== 8'h00) begin bad++; $display("FAIL clear_last got=%h want=00", last_result); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok; int pulses;
    rnd = 16'h0011; mode = 1'b0; wr_log.delete(); pulses = 0;
    @(negedge clock);
    start = 1'b1;
    for (int k = 0; k < 200 && pulses < 2; k++) begin
      @(negedge clock);
      if (refreshed) pulses++;
    end
    start = 1'b0;
    wait_idle(200, cyc, ok);
    total++; if (!ok || pulses != 2 || wr_log.size() != 12) begin bad++; $display("FAIL b2b got=%0d/%0d want=2/12", pulses, wr_log.size()); end
  endtask

  task automatic test_timeout;
    int cyc; bit ok;
    rnd = 16'h0033; wr_log.delete(); refresh_cnt = 0; dp_silent = 1'b1;
    do_start(1'b0);
    wait_idle(400, cyc, ok);
    total++; if (!ok || cyc != 259) begin bad++; $display("FAIL to_cycles got=%0d want=259", cyc); end
    total++; if (error_flag !== 1'b1) begin bad++; $display("FAIL to_error got=%b want=1", error_flag); end
    total++; if (refresh_cnt != 0 || wr_log.size() != 1) begin bad++; $display("FAIL to_abandon got=%0d/%0d want=0/1", refresh_cnt, wr_log.size()); end
    dp_silent = 1'b0; refresh_cnt = 0;
    do_start(1'b0);
    total++; if (error_flag !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", error_flag); end
    wait_idle(200, cyc, ok);
    total++; if (!ok || refresh_cnt != 1 || error_flag !== 1'b0) begin bad++; $display("FAIL to_recover got=%0d/%b want=1/0", refresh_cnt, error_flag); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit ok; int rises; bit prev;
    rnd = 16'h0099; rises = 0; prev = 1'b0;
    do_start(1'b0);
    for (int k = 0; k < 100 && rises < 3; k++) begin
      @(negedge clock);
      if (start_dp && !prev) rises++;
      prev = start_dp;
    end
    @(negedge clock);
    total++; if (start_dp !== 1'b1) begin bad++; $display("FAIL mid_hold got=%b want=1", start_dp); end
    resetn = 1'b0;
    #1;
    total++; if (start_dp !== 1'b0 || finished !== 1'b1) begin bad++; $display("FAIL mid_reset got=%b%b want=01", start_dp, finished); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    wr_log.delete(); refresh_cnt = 0;
    do_start(1'b0);
    wait_idle(200, cyc, ok);
    total++; if (!ok || wr_log.size() != 6 || refresh_cnt != 1) begin bad++; $display("FAIL mid_restart got=%0d/%0d want=6/1", wr_log.size(), refresh_cnt); end
    total++; if (wr_log.size() == 0 || wr_log[0] !== 20'h99402) begin bad++; $display("FAIL mid_first got=%h want=99402", (wr_log.size() != 0) ? wr_log[0] : 20'h0); end
  endtask

  task automatic test_early_finish;
    int cyc; bit ok;
    rnd = 16'h005A; wr_log.delete(); refresh_cnt = 0; force_early = 1'b1;
    do_start(1'b0);
    wait_idle(200, cyc, ok);
    force_early = 1'b0;
    total++; if (!ok || cyc != 32) begin bad++; $display("FAIL early_cycles got=%0d want=32", cyc); end
    total++; if (wr_log.size() != 6 || refresh_cnt != 1) begin bad++; $display("FAIL early_pass got=%0d/%0d want=6/1", wr_log.size(), refresh_cnt); end
    total++; if (last_result !== 8'h5A) begin bad++; $display("FAIL early_last got=%h want=5a", last_result); end
  endtask

  initial begin
    start = 1'b0; mode = 1'b0; rnd = 16'h0; gen_duration = 16'd0;
    test_reset();
    test_full_pass();
    test_skip();
    test_clear_mode();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_early_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
